// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline-stage definitions: stage state encoding, bundle widths and
// control-bundle field positions so every stage packs and unpacks alike.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } stageState_e;

  localparam int IF_ID_CTRL_W  = 24;
  localparam int IF_ID_DATA_W  = 64;
  localparam int ID_EX_CTRL_W  = 24;
  localparam int ID_EX_DATA_W  = 128;
  localparam int EX_MEM_CTRL_W = 24;
  localparam int EX_MEM_DATA_W = 128;
  localparam int MEM_WB_CTRL_W = 24;
  localparam int MEM_WB_DATA_W = 96;

  localparam int CTRL_REGWRITE   = 0;
  localparam int CTRL_MEMREAD    = 1;
  localparam int CTRL_MEMWRITE   = 2;
  localparam int CTRL_ALUOP_LSB  = 3;
  localparam int CTRL_ALUOP_MSB  = 6;
  localparam int CTRL_BRANCHJUMP = 7;
  localparam int CTRL_MEMTOREG   = 8;
  localparam int CTRL_ALUSRC     = 9;

  function automatic logic [1:0] stateOccupancy(input stageState_e s);
    logic [1:0] occ;
    case (s)
      EMPTY:   occ = 2'd0;
      BUSY:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready bus carrying one control bundle and one datapath bundle.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_stage_reg_entry.sv
// One ctrl+data holding register with load, synchronous clear and async reset.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] dCtrl,
  input  logic [DATA_W-1:0] dData,
  output logic [CTRL_W-1:0] qCtrl,
  output logic [DATA_W-1:0] qData
);

  // Entry storage; clear beats load so a flushed cycle never captures.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qCtrl <= '0;
      qData <= '0;
    end else if (clear) begin
      qCtrl <= '0;
      qData <= '0;
    end else if (load) begin
      qCtrl <= dCtrl;
      qData <= dData;
    end else begin
      qCtrl <= qCtrl;
      qData <= qData;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, hazard stall and flush-to-bubble; invalid entries expose zero control.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 24,
  parameter int SKID   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic stall,
  pipe_stage_reg_if.slave  inBus,
  pipe_stage_reg_if.master outBus,
  output logic [1:0] occupancy
);

  stageState_e       stateQ, nextState;
  logic              readyQ, readyS, outValidS, acceptS, drainS;
  logic              loadMainS, loadSkidS, mainFromSkidS;
  logic [1:0]        occQ;
  logic [CTRL_W-1:0] mainCtrl, skidCtrl, mainCtrlIn;
  logic [DATA_W-1:0] mainData, skidData, mainDataIn;

  assign outValidS = (stateQ != EMPTY);
  assign acceptS   = inBus.valid & readyS;
  assign drainS    = outValidS & outBus.ready;

  generate
    if (SKID != 0) begin : gSkid
      assign readyS = readyQ & ~stall;
      pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) skidReg (
        .clk(clk), .rst_n(rst_n), .load(loadSkidS), .clear(flush),
        .dCtrl(inBus.ctrl), .dData(inBus.data),
        .qCtrl(skidCtrl), .qData(skidData)
      );
    end else begin : gNoSkid
      assign readyS   = (~outValidS | outBus.ready) & ~stall;
      assign skidCtrl = '0;
      assign skidData = '0;
    end
  endgenerate

  assign mainCtrlIn = mainFromSkidS ? skidCtrl : inBus.ctrl;
  assign mainDataIn = mainFromSkidS ? skidData : inBus.data;

  pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) mainReg (
    .clk(clk), .rst_n(rst_n), .load(loadMainS), .clear(flush),
    .dCtrl(mainCtrlIn), .dData(mainDataIn),
    .qCtrl(mainCtrl), .qData(mainData)
  );

  // Next-state and entry-load decode; flush overrides every other event.
  always_comb begin
    nextState     = stateQ;
    loadMainS     = 1'b0;
    loadSkidS     = 1'b0;
    mainFromSkidS = 1'b0;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (stateQ)
        EMPTY: begin
          if (acceptS) begin
            nextState = BUSY;
            loadMainS = 1'b1;
          end else begin
            nextState = EMPTY;
          end
        end
        BUSY: begin
          if (acceptS && drainS) begin
            loadMainS = 1'b1;
          end else if (acceptS && (SKID != 0)) begin
            nextState = FULL;
            loadSkidS = 1'b1;
          end else if (drainS) begin
            nextState = EMPTY;
          end else begin
            nextState = BUSY;
          end
        end
        FULL: begin
          if (drainS) begin
            nextState     = BUSY;
            loadMainS     = 1'b1;
            mainFromSkidS = 1'b1;
          end else begin
            nextState = FULL;
          end
        end
        default: nextState = EMPTY;
      endcase
    end
  end

  // State, registered ready and occupancy all follow the decoded next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= EMPTY;
      readyQ <= 1'b1;
      occQ   <= 2'd0;
    end else begin
      stateQ <= nextState;
      readyQ <= (nextState != FULL);
      occQ   <= stateOccupancy(nextState);
    end
  end

  assign inBus.ready  = readyS;
  assign outBus.valid = outValidS;
  assign outBus.ctrl  = mainCtrl & {CTRL_W{outValidS}};
  assign outBus.data  = mainData;
  assign occupancy    = occQ;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid build and a single-entry build.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = 24;
  localparam int DW = 128;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       stall = 1'b0;
  logic [1:0] occ, occ0;
  int         nCompared = 0;
  int         nMismatched = 0;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up0 ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn0 ();

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .inBus(up.slave), .outBus(dn.master), .occupancy(occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .inBus(up0.slave), .outBus(dn0.master), .occupancy(occ0)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [23:0] c, input logic [127:0] d);
    up.valid = v;
    up.ctrl  = c;
    up.data  = d;
  endtask

  initial begin
    drive(1'b0, 24'h0, 128'h0);
    dn.ready  = 1'b0;
    up0.valid = 1'b0;
    up0.ctrl  = 24'h0;
    up0.data  = 128'h0;
    dn0.ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkVal("rst_valid", 128'(dn.valid), 128'h0);
    checkVal("rst_ctrl", 128'(dn.ctrl), 128'h0);
    checkVal("rst_data", dn.data, 128'h0);
    checkVal("rst_occ", 128'(occ), 128'h0);
    checkVal("rst_ready", 128'(up.ready), 128'h1);

    // single entry, 1-cycle latency
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 24'h00000F, 128'hAB);
    dn.ready = 1'b1;
    step();
    checkVal("one_valid", 128'(dn.valid), 128'h1);
    checkVal("one_ctrl", 128'(dn.ctrl), 128'hF);
    checkVal("one_data", dn.data, 128'hAB);
    checkVal("one_occ", 128'(occ), 128'h1);
    drive(1'b0, 24'h0, 128'h0);
    step();
    checkVal("one_bubble_valid", 128'(dn.valid), 128'h0);
    checkVal("one_bubble_ctrl", 128'(dn.ctrl), 128'h0);
    checkVal("one_hold_data", dn.data, 128'hAB);
    checkVal("one_bubble_occ", 128'(occ), 128'h0);

    // backpressure fill, then drain in order with no gaps
    dn.ready = 1'b0;
    drive(1'b1, 24'h1, 128'h1);
    step();
    checkVal("bp_occ_a", 128'(occ), 128'h1);
    drive(1'b1, 24'h2, 128'h2);
    step();
    checkVal("bp_occ_full", 128'(occ), 128'h2);
    checkVal("bp_ready_full", 128'(up.ready), 128'h0);
    checkVal("bp_head_a", dn.data, 128'h1);
    drive(1'b1, 24'h3, 128'h3);
    step();
    checkVal("bp_hold_occ", 128'(occ), 128'h2);
    checkVal("bp_hold_head", dn.data, 128'h1);
    dn.ready = 1'b1;
    #1;
    checkVal("bp_out_a_valid", 128'(dn.valid), 128'h1);
    checkVal("bp_out_a", dn.data, 128'h1);
    step();
    checkVal("bp_out_b_valid", 128'(dn.valid), 128'h1);
    checkVal("bp_out_b", dn.data, 128'h2);
    checkVal("bp_out_b_ctrl", 128'(dn.ctrl), 128'h2);
    step();
    checkVal("bp_out_c_valid", 128'(dn.valid), 128'h1);
    checkVal("bp_out_c", dn.data, 128'h3);
    drive(1'b0, 24'h0, 128'h0);
    step();
    checkVal("bp_empty_valid", 128'(dn.valid), 128'h0);
    checkVal("bp_empty_occ", 128'(occ), 128'h0);

    // stall inserts one bubble
    stall = 1'b1;
    drive(1'b1, 24'h55, 128'h55);
    #1;
    checkVal("stall_ready", 128'(up.ready), 128'h0);
    step();
    checkVal("stall_bubble_valid", 128'(dn.valid), 128'h0);
    checkVal("stall_bubble_ctrl", 128'(dn.ctrl), 128'h0);
    stall = 1'b0;
    #1;
    checkVal("unstall_ready", 128'(up.ready), 128'h1);
    step();
    checkVal("stall_x_valid", 128'(dn.valid), 128'h1);
    checkVal("stall_x_data", dn.data, 128'h55);
    checkVal("stall_x_ctrl", 128'(dn.ctrl), 128'h55);
    drive(1'b0, 24'h0, 128'h0);
    step();

    // flush while full drops everything including the presented entry
    dn.ready = 1'b0;
    drive(1'b1, 24'h11, 128'h11);
    step();
    drive(1'b1, 24'h22, 128'h22);
    step();
    checkVal("fl_occ_full", 128'(occ), 128'h2);
    flush = 1'b1;
    drive(1'b1, 24'h77, 128'h77);
    #1;
    checkVal("fl_head_visible", dn.data, 128'h11);
    step();
    flush = 1'b0;
    drive(1'b0, 24'h0, 128'h0);
    checkVal("fl_occ", 128'(occ), 128'h0);
    checkVal("fl_valid", 128'(dn.valid), 128'h0);
    checkVal("fl_ctrl", 128'(dn.ctrl), 128'h0);
    checkVal("fl_data", dn.data, 128'h0);
    checkVal("fl_ready", 128'(up.ready), 128'h1);
    dn.ready = 1'b1;
    step();
    checkVal("fl_d_dropped", 128'(dn.valid), 128'h0);

    // asynchronous reset between edges while full
    dn.ready = 1'b0;
    drive(1'b1, 24'h31, 128'h31);
    step();
    drive(1'b1, 24'h32, 128'h32);
    step();
    checkVal("ar_occ_full", 128'(occ), 128'h2);
    drive(1'b0, 24'h0, 128'h0);
    #3 rst_n = 1'b0;
    #1;
    checkVal("ar_occ", 128'(occ), 128'h0);
    checkVal("ar_valid", 128'(dn.valid), 128'h0);
    checkVal("ar_ctrl", 128'(dn.ctrl), 128'h0);
    checkVal("ar_data", dn.data, 128'h0);
    #2 rst_n = 1'b1;
    step();

    // single-entry build: ready tracks out_ready combinationally
    up0.valid = 1'b1;
    up0.ctrl  = 24'h10;
    up0.data  = 128'h10;
    dn0.ready = 1'b1;
    #1;
    checkVal("s0_ready_empty", 128'(up0.ready), 128'h1);
    step();
    checkVal("s0_out0_valid", 128'(dn0.valid), 128'h1);
    checkVal("s0_out0", dn0.data, 128'h10);
    up0.ctrl = 24'h11;
    up0.data = 128'h11;
    #1;
    checkVal("s0_ready_flow", 128'(up0.ready), 128'h1);
    step();
    checkVal("s0_out1", dn0.data, 128'h11);
    dn0.ready = 1'b0;
    up0.ctrl  = 24'h12;
    up0.data  = 128'h12;
    #1;
    checkVal("s0_ready_blocked", 128'(up0.ready), 128'h0);
    step();
    checkVal("s0_hold_out1", dn0.data, 128'h11);
    checkVal("s0_hold_occ", 128'(occ0), 128'h1);
    dn0.ready = 1'b1;
    #1;
    checkVal("s0_ready_resume", 128'(up0.ready), 128'h1);
    step();
    checkVal("s0_out2", dn0.data, 128'h12);
    checkVal("s0_out2_ctrl", 128'(dn0.ctrl), 128'h12);
    up0.valid = 1'b0;
    step();
    checkVal("s0_empty_valid", 128'(dn0.valid), 128'h0);
    checkVal("s0_empty_ctrl", 128'(dn0.ctrl), 128'h0);
    checkVal("s0_empty_occ", 128'(occ0), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register (successor to the fixed-field ID/EX register) carrying a packed control bundle and a packed datapath bundle between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, an optional 2-entry skid buffer, a hazard-unit stall, and flush-to-bubble semantics.
- When an entry is not valid, its control bits are forced to zero, so bubbles never write registers or memory.

Parameters:
- DATA_W, 128, width of the datapath bundle (PC+4, operands, offset, register IDs, ...).
- CTRL_W, 24, width of the control bundle (regWrite, MemRead, MemWrite, ALUOp, ...).
- SKID, 1, 1 = 2-entry skid buffer with registered ready; 0 = single entry with combinational ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush: discard all entries.
- stall  in  1  hazard-unit stall: block acceptance from upstream.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream datapath bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry.
- out_ctrl  out  CTRL_W  head control; zero whenever out_valid=0.
- out_data  out  DATA_W  head datapath bundle.
- occupancy  out  2  number of valid entries (0..2).

Behaviour:
- Definitions: accept = in_valid & in_ready; drain = out_valid & out_ready.
- Reset (rst_n=0, asynchronous): state EMPTY; main and skid registers zero; out_valid=0, out_ctrl=0, out_data=0, occupancy=0; ready_q=1.
- Latency: an accepted entry appears on out_* on the next cycle (1-cycle latency). Throughput is 1 entry per cycle while out_ready=1.
- SKID=1 states (main = head register, skid = overflow register):
  - EMPTY: accept -> BUSY, main<=in.
  - BUSY:
    - accept & drain -> BUSY, main<=in.
    - accept & !drain -> FULL, skid<=in.
    - !accept & drain -> EMPTY.
    - Otherwise hold.
  - FULL: accept is impossible. drain -> BUSY, main<=skid. Otherwise hold.
- Ready, SKID=1: ready_q <= (next_state != FULL); in_ready = ready_q & ~stall.
- SKID=0:
  - Single register, no skid.
  - in_ready = (~out_valid | out_ready) & ~stall.
  - States are EMPTY/BUSY only.
- Stall:
  - Stall affects only acceptance. in_in_ready=0 while stall=1, so no entry is accepted.
  - Drain continues normally under stall.
  - A stall with out_ready=1 therefore empties the stage, emitting bubbles downstream (load-use bubble insertion).
- Flush:
  - Highest priority, above accept, drain and stall.
  - Next state EMPTY; main/skid ctrl and data cleared to zero; ready_q=1.
  - An entry presented with in_valid=1 in the flush cycle is dropped even if in_ready=1.
  - The head entry is still visible to downstream during the flush cycle. A drain in that same cycle completes normally (downstream sees one transfer).
- Output gating: out_ctrl = main_ctrl & {CTRL_W{out_valid}}. out_data is not gated and holds its last value while invalid, except when zeroed by reset or flush.
- occupancy: EMPTY=0, BUSY=1, FULL=2.
- Data integrity: entries leave in FIFO order and are never duplicated or lost, except when discarded by flush.
- Reset asserted mid-transfer: all state is cleared immediately; upstream must re-present the entry after rst_n rises.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage state enum (EMPTY, BUSY, FULL);
  - per-stage CTRL_W/DATA_W constants;
  - bit-index localparams for the control bundle fields (REGWRITE, MEMREAD, MEMWRITE, ALUOP, BRANCHJUMP, ...), so every stage packs and unpacks identically.
- One natural sub-module, pipe_entry_reg: a single ctrl+data register with load, clear and async reset. It is instantiated twice (main, skid) when SKID=1 and once when SKID=0.

Test Plan:
- Reset then one entry: rst_n 0->1, in_valid=1, in_ctrl=0x00000F, in_data=0xAB, out_ready=1 -> next cycle out_valid=1, out_ctrl=0x00000F, out_data=0xAB, occupancy=1. The cycle after, with in_valid=0: out_valid=0, out_ctrl=0.
- Backpressure fill (SKID=1): out_ready=0, stream entries A=1, B=2, C=3 -> A and B accepted, occupancy=2, in_ready=0 on the cycle after B. C is held upstream. Then out_ready=1 -> outputs A, B, C in order with no gaps.
- Stall bubble: stall=1 for one cycle with in_valid=1 (X=0x55), out_ready=1 -> X not accepted. Downstream sees out_valid=0 and out_ctrl=0 for one cycle. X appears the cycle after stall drops.
- Flush while FULL: occupancy=2, assert flush with in_valid=1 (D=0x77) -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1. D is never emitted.
- Async reset mid-stream: drop rst_n between clock edges with occupancy=2 -> outputs go to zero immediately, without waiting for clk.
- SKID=0 build: out_ready toggling 1,0,1 with continuous input -> in_ready follows out_ready combinationally in the same cycle. Throughput is 1 entry/cycle when out_ready=1, and there is no loss or duplication.
